lab5_g7_capture: RTL and testbench

Input-capture timer: measures the period and high time of an external digital signal. Both results are counted in prescaler ticks, using the same tick scheme as the lab5 down-counting timer. It is the receive side of the timer pair: the down-counter generates timed events, and this block measures them. Typical use is to loop the timer's `bitti` output, or a square wave derived from it, back into `sig_in` and check the reload/prescaler timing.

---
 rtl/lab5_g7_capture_pkg.sv | 7 +
 rtl/lab5_g7_capture_if.sv | 17 +
 rtl/lab5_g7_capture_psc.sv | 29 ++
 rtl/lab5_g7_capture.sv | 103 ++++++++++
 tb/tb_lab5_g7_capture.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lab5_g7_capture_pkg.sv
// Shared widths and FSM encoding for the lab5 input-capture timer.
package lab5_g7_pkg;
  localparam int CNT_W = 16;
  localparam int PSC_W = 5;

  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} cap_state_t;
endpackage

// File: rtl/lab5_g7_capture_if.sv
// Control/result bundle of the capture timer; master drives controls, slave returns results.
interface lab5_g7_capture_if #(
  parameter int CNT_W = lab5_g7_pkg::CNT_W,
  parameter int PSC_W = lab5_g7_pkg::PSC_W
);
  logic             en;
  logic [PSC_W-1:0] psc;
  logic             sig_in;
  logic             ovf_clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high;
  logic             valid;
  logic             ovf;

  modport master (output en, psc, sig_in, ovf_clr, input period, high, valid, ovf);
  modport slave  (input en, psc, sig_in, ovf_clr, output period, high, valid, ovf);
endinterface

// File: rtl/lab5_g7_capture_psc.sv
// Tick prescaler: one tick every psc+1 cycles, restarted whenever psc changes.
module lab5_g7_cap_psc #(
  parameter int PSC_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);
  logic [PSC_W-1:0] pcnt;
  logic [PSC_W-1:0] psc_q;
  logic             psc_chg;

  assign psc_chg = (psc != psc_q);
  // A new setting suppresses the tick so the first interval is a full psc+1 cycles.
  assign tick    = en & ~psc_chg & (pcnt == psc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt  <= '0;
      psc_q <= '0;
    end else begin
      psc_q <= psc;
      if (!en || psc_chg || tick) pcnt <= '0;
      else                        pcnt <= pcnt + 1'b1;
    end
  end
endmodule

// File: rtl/lab5_g7_capture.sv
// Input-capture timer: period and high time of sig_in, counted in prescaler ticks.
module lab5_g7_capture #(
  parameter int CNT_W = lab5_g7_pkg::CNT_W,
  parameter int PSC_W = lab5_g7_pkg::PSC_W
) (
  input  logic              clk,
  input  logic              reset,
  lab5_g7_capture_if.slave  bus
);
  import lab5_g7_pkg::*;

  cap_state_t       state;
  logic             s1, s2, s3;
  logic             rise, fall, tick, sat;
  logic [CNT_W-1:0] cnt, cnt_inc, high_tmp;

  lab5_g7_cap_psc #(.PSC_W(PSC_W)) u_psc (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .psc   (bus.psc),
    .tick  (tick)
  );

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  // Captures include the tick of the current cycle so back-to-back periods lose nothing.
  assign cnt_inc = cnt + CNT_W'(tick);
  assign sat     = tick & (cnt == {CNT_W{1'b1}});

  // Synchronizer runs regardless of en so re-enabling never sees a stale edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      high_tmp   <= '0;
      bus.period <= '0;
      bus.high   <= '0;
      bus.valid  <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      if (bus.ovf_clr) bus.ovf <= 1'b0;
      if (!bus.en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              cnt   <= '0;
              state <= MEAS_HIGH;
            end
          end
          MEAS_HIGH: begin
            if (sat) begin
              bus.ovf <= 1'b1;
              cnt     <= '0;
              state   <= IDLE;
            end else begin
              cnt <= cnt_inc;
              if (fall) begin
                high_tmp <= cnt_inc;
                state    <= MEAS_LOW;
              end
            end
          end
          MEAS_LOW: begin
            if (sat) begin
              bus.ovf <= 1'b1;
              cnt     <= '0;
              state   <= IDLE;
            end else if (rise) begin
              bus.period <= cnt_inc;
              bus.high   <= high_tmp;
              bus.valid  <= 1'b1;
              cnt        <= '0;
              state      <= MEAS_HIGH;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lab5_g7_capture.sv
// Directed bench for lab5_g7_capture; expected results queue up as edges are driven.
module tb_lab5_g7_capture;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lab5_g7_capture_if bus();

  lab5_g7_capture dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] period;
    logic [15:0] high;
    int          gap;
    bit          vchk;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_v = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    cyc++;
    if (bus.valid === 1'b1) begin
      if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        if (e.vchk) begin
          chk("period", 32'(bus.period), 32'(e.period));
          chk("high", 32'(bus.high), 32'(e.high));
        end
        if (e.gap != 0) chk("valid_gap", 32'(cyc - last_v), 32'(e.gap));
      end
      last_v = cyc;
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One sig_in period; its rising edge closes the previous period (push=1 queues that result).
  task automatic pulse(input int hi, input int lo, input bit push,
                       input logic [15:0] ep, input logic [15:0] eh, input int gap);
    if (push) q.push_back('{ep, eh, gap, 1'b1});
    bus.sig_in = 1'b1;
    cyc_n(hi);
    bus.sig_in = 1'b0;
    cyc_n(lo);
  endtask

  task automatic close(input logic [15:0] ep, input logic [15:0] eh, input int gap);
    q.push_back('{ep, eh, gap, 1'b1});
    bus.sig_in = 1'b1;
    cyc_n(4);
  endtask

  task automatic seg_end();
    bus.sig_in = 1'b0;
    cyc_n(6);
    chk("queue_drained", 32'(q.size()), 32'd0);
    bus.en = 1'b0;
    cyc_n(1);
    bus.en = 1'b1;
    cyc_n(2);
  endtask

  initial begin
    int n;
    bus.en      = 1'b0;
    bus.psc     = '0;
    bus.sig_in  = 1'b0;
    bus.ovf_clr = 1'b0;
    reset       = 1'b0;
    cyc_n(3);
    chk("rst_period", 32'(bus.period), 32'd0);
    chk("rst_high", 32'(bus.high), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    reset  = 1'b1;
    bus.en = 1'b1;
    cyc_n(2);

    // psc=0, 4 high / 6 low
    pulse(4, 6, 1'b0, 16'd0, 16'd0, 0);
    q.push_back('{16'd10, 16'd4, 0, 1'b1});
    bus.sig_in = 1'b1;
    cyc_n(2);
    chk("latency_early", 32'(bus.valid), 32'd0);
    cyc_n(1);
    chk("latency", 32'(bus.valid), 32'd1);
    cyc_n(1);
    bus.sig_in = 1'b0;
    cyc_n(6);
    pulse(4, 6, 1'b1, 16'd10, 16'd4, 10);
    pulse(4, 6, 1'b1, 16'd10, 16'd4, 10);
    close(16'd10, 16'd4, 10);
    seg_end();

    // psc=3, 8 high / 8 low
    bus.psc = 5'd3;
    cyc_n(4);
    pulse(8, 8, 1'b0, 16'd0, 16'd0, 0);
    pulse(8, 8, 1'b1, 16'd4, 16'd2, 0);
    pulse(8, 8, 1'b1, 16'd4, 16'd2, 16);
    close(16'd4, 16'd2, 16);
    seg_end();

    // psc 3 -> 1 in the middle of a period
    pulse(8, 8, 1'b0, 16'd0, 16'd0, 0);
    pulse(8, 8, 1'b1, 16'd4, 16'd2, 0);
    q.push_back('{16'd4, 16'd2, 16, 1'b1});
    bus.sig_in = 1'b1;
    cyc_n(3);
    bus.psc = 5'd1;
    cyc_n(5);
    bus.sig_in = 1'b0;
    cyc_n(8);
    q.push_back('{16'd0, 16'd0, 16, 1'b0});
    pulse(8, 8, 1'b0, 16'd0, 16'd0, 0);
    close(16'd8, 16'd4, 16);
    seg_end();

    // en dropped mid-period, sig_in keeps toggling
    bus.psc = 5'd0;
    cyc_n(3);
    pulse(5, 5, 1'b0, 16'd0, 16'd0, 0);
    pulse(5, 5, 1'b1, 16'd10, 16'd5, 0);
    q.push_back('{16'd10, 16'd5, 10, 1'b1});
    bus.sig_in = 1'b1;
    cyc_n(4);
    bus.en = 1'b0;
    cyc_n(1);
    bus.sig_in = 1'b0;
    cyc_n(5);
    bus.sig_in = 1'b1;
    cyc_n(5);
    bus.sig_in = 1'b0;
    cyc_n(3);
    chk("en_hold_period", 32'(bus.period), 32'd10);
    chk("en_hold_high", 32'(bus.high), 32'd5);
    bus.en = 1'b1;
    cyc_n(2);
    pulse(6, 4, 1'b0, 16'd0, 16'd0, 0);
    pulse(6, 4, 1'b1, 16'd10, 16'd6, 0);
    close(16'd10, 16'd6, 10);
    seg_end();

    // saturation: arm, then hold low until the counter wraps
    bus.sig_in = 1'b1;
    cyc_n(2);
    bus.sig_in = 1'b0;
    n = 0;
    while (bus.ovf !== 1'b1 && n < 70000) begin
      cyc_n(1);
      n++;
    end
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    chk("sat_period_held", 32'(bus.period), 32'd10);
    chk("sat_high_held", 32'(bus.high), 32'd6);
    cyc_n(10);
    chk("ovf_sticky", 32'(bus.ovf), 32'd1);
    bus.ovf_clr = 1'b1;
    cyc_n(1);
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.ovf), 32'd0);
    chk("queue_after_sat", 32'(q.size()), 32'd0);

    // reset mid-measurement, then first rise must only arm
    pulse(3, 3, 1'b0, 16'd0, 16'd0, 0);
    pulse(3, 3, 1'b1, 16'd6, 16'd3, 0);
    bus.sig_in = 1'b1;
    cyc_n(1);
    reset = 1'b0;
    bus.sig_in = 1'b0;
    cyc_n(1);
    chk("mid_rst_period", 32'(bus.period), 32'd0);
    chk("mid_rst_high", 32'(bus.high), 32'd0);
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    cyc_n(1);
    reset = 1'b1;
    cyc_n(3);
    pulse(3, 3, 1'b0, 16'd0, 16'd0, 0);
    pulse(3, 3, 1'b1, 16'd6, 16'd3, 0);
    close(16'd6, 16'd3, 6);
    seg_end();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
